// File: rtl/multi_mips_control_fsm.sv
// Main controller for the multi-cycle MIPS core: sequences fetch, decode, execute,
// memory and write-back steps and decodes the datapath controls from the current state.
module multi_mips_control_fsm (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] OPCODE,
    input  logic       ZERO,
    input  logic       MEM_READY,
    output logic       I_OR_D,
    output logic       MEM_WRITE,
    output logic       IR_WRITE,
    output logic       REG_DST,
    output logic       MEM_TO_REG,
    output logic       REG_WRITE,
    output logic       ALU_SRC_A,
    output logic [1:0] ALU_SRC_B,
    output logic [1:0] ALU_OP,
    output logic [1:0] PC_SRC,
    output logic       PC_EN,
    output logic       INSTR_DONE,
    output logic       ILLEGAL_OP,
    output logic [3:0] STATE
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state;
    logic   pc_write;
    logic   branch;

    // States that touch memory hold until MEM_READY so every access completes exactly once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:   if (MEM_READY) state <= S_DECODE;
                S_DECODE: begin
                    case (OPCODE)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_RTYPE:     state <= S_EXECUTE;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_ADDI:      state <= S_ADDIEX;
                        OP_J:         state <= S_JUMP;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR:  state <= (OPCODE == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   if (MEM_READY) state <= S_MEMWB;
                S_MEMWR:   if (MEM_READY) state <= S_FETCH;
                S_EXECUTE: state <= S_ALUWB;
                S_ADDIEX:  state <= S_ADDIWB;
                default:   state <= S_FETCH;
            endcase
        end
    end

    // Controls are gated by RST so no write strobe can leak out while reset is held.
    always_comb begin
        I_OR_D     = 1'b0;
        MEM_WRITE  = 1'b0;
        IR_WRITE   = 1'b0;
        REG_DST    = 1'b0;
        MEM_TO_REG = 1'b0;
        REG_WRITE  = 1'b0;
        ALU_SRC_A  = 1'b0;
        ALU_SRC_B  = 2'b00;
        ALU_OP     = 2'b00;
        PC_SRC     = 2'b00;
        INSTR_DONE = 1'b0;
        ILLEGAL_OP = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        if (!RST) begin
            case (state)
                S_FETCH: begin
                    ALU_SRC_B = 2'b01;
                    IR_WRITE  = MEM_READY;
                    pc_write  = MEM_READY;
                end
                S_DECODE: begin
                    ALU_SRC_B = 2'b11;
                    case (OPCODE)
                        OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ILLEGAL_OP = 1'b0;
                        default: ILLEGAL_OP = 1'b1;
                    endcase
                end
                S_MEMADR, S_ADDIEX: begin
                    ALU_SRC_A = 1'b1;
                    ALU_SRC_B = 2'b10;
                end
                S_MEMRD: I_OR_D = 1'b1;
                S_MEMWB: begin
                    MEM_TO_REG = 1'b1;
                    REG_WRITE  = 1'b1;
                    INSTR_DONE = 1'b1;
                end
                S_MEMWR: begin
                    I_OR_D     = 1'b1;
                    MEM_WRITE  = 1'b1;
                    INSTR_DONE = MEM_READY;
                end
                S_EXECUTE: begin
                    ALU_SRC_A = 1'b1;
                    ALU_OP    = 2'b10;
                end
                S_ALUWB: begin
                    REG_DST    = 1'b1;
                    REG_WRITE  = 1'b1;
                    INSTR_DONE = 1'b1;
                end
                S_BRANCH: begin
                    ALU_SRC_A  = 1'b1;
                    ALU_OP     = 2'b01;
                    PC_SRC     = 2'b01;
                    branch     = 1'b1;
                    INSTR_DONE = 1'b1;
                end
                S_ADDIWB: begin
                    REG_WRITE  = 1'b1;
                    INSTR_DONE = 1'b1;
                end
                S_JUMP: begin
                    PC_SRC     = 2'b10;
                    pc_write   = 1'b1;
                    INSTR_DONE = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign PC_EN = pc_write | (branch & ZERO);
    assign STATE = state;

endmodule

// File: doc/multi_mips_control_fsm.md
# multi_mips_control_fsm

- Moore-style main controller for the multi-cycle variant of our MIPS core.
- Sequences the shared datapath (one memory, one ALU, instruction register, PC) through fetch, decode, execute, memory and write-back steps per instruction.
- Drives the 2-bit ALU_OP consumed by the ALU decoder.
- Waits on a memory-ready handshake for every memory access.

## Interface
Parameters:
- none. The state encoding is fixed at 4 bits: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- OPCODE  in  6  instr[31:26] from the instruction register.
- ZERO  in  1  ALU zero flag.
- MEM_READY  in  1  memory has completed the current access this cycle.
- I_OR_D  out  1  memory address select: 0 = PC, 1 = ALU result register.
- MEM_WRITE  out  1  memory write request.
- IR_WRITE  out  1  instruction register load.
- REG_DST  out  1  write register select: 1 = rd, 0 = rt.
- MEM_TO_REG  out  1  write-back data select: 1 = memory data, 0 = ALU result.
- REG_WRITE  out  1  register file write enable.
- ALU_SRC_A  out  1  ALU A select: 0 = PC, 1 = register A.
- ALU_SRC_B  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- ALU_OP  out  2  ALU decoder operation: 00 = add, 01 = subtract, 10 = use funct. The value 11 is never driven.
- PC_SRC  out  2  PC source: 00 = ALU result, 01 = ALU output register, 10 = jump target.
- PC_EN  out  1  equals PC_WRITE | (BRANCH & ZERO).
- INSTR_DONE  out  1  one-cycle pulse in the last cycle of each instruction.
- ILLEGAL_OP  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- STATE  out  4  current state, for debug.

## Operation
Supported opcodes:
- R-type 000000
- lw 100011
- sw 101011
- beq 000100
- addi 001000
- j 000010

State transitions:
- FETCH -> DECODE when MEM_READY=1; otherwise hold in FETCH.
- DECODE -> MEMADR (lw/sw), EXECUTE (R-type), BRANCH (beq), ADDIEX (addi), JUMP (j).
- DECODE -> FETCH for any other opcode, with ILLEGAL_OP=1 during that DECODE cycle.
- MEMADR -> MEMRD (lw) or MEMWR (sw).
- MEMRD -> MEMWB when MEM_READY=1; otherwise hold.
- MEMWR -> FETCH when MEM_READY=1; otherwise hold.
- EXECUTE -> ALUWB; ADDIEX -> ADDIWB.
- MEMWB, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.

Outputs per state (any output not listed is 0):
- FETCH: ALU_SRC_B=01, ALU_OP=00, PC_SRC=00, I_OR_D=0. IR_WRITE = PC_WRITE = MEM_READY.
- DECODE: ALU_SRC_A=0, ALU_SRC_B=11, ALU_OP=00 (branch target precompute).
- MEMADR and ADDIEX: ALU_SRC_A=1, ALU_SRC_B=10, ALU_OP=00.
- MEMRD: I_OR_D=1.
- MEMWB: MEM_TO_REG=1, REG_WRITE=1, REG_DST=0.
- MEMWR: I_OR_D=1, MEM_WRITE=1. MEM_WRITE is held for every wait cycle.
- EXECUTE: ALU_SRC_A=1, ALU_SRC_B=00, ALU_OP=10.
- ALUWB: REG_DST=1, REG_WRITE=1.
- BRANCH: ALU_SRC_A=1, ALU_SRC_B=00, ALU_OP=01, PC_SRC=01, internal BRANCH=1.
- ADDIWB: REG_WRITE=1, REG_DST=0.
- JUMP: PC_SRC=10, PC_WRITE=1.

INSTR_DONE:
- Asserted in MEMWB, ALUWB, BRANCH, ADDIWB and JUMP.
- Asserted in MEMWR only when MEM_READY=1.

## Timing
- Registered state only. All outputs are a combinational decode of STATE plus MEM_READY/ZERO/OPCODE as listed above. No output registers.
- While RST=1: state is forced to FETCH asynchronously, and all outputs except STATE are forced to 0, so no write strobe can occur during reset. STATE reads 0.
- The first fetch starts on the first rising CLK edge after RST deasserts.
- Latency with MEM_READY tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles. Each MEM_READY=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- The PC and IR update only on the FETCH cycle where MEM_READY=1. There is no double increment across wait cycles.
- BRANCH: PC_EN=1 only if ZERO=1 in that cycle.
- An illegal opcode costs 2 cycles (FETCH, DECODE) and then a clean refetch.
- RST asserted mid-instruction (including during a MEMWR wait) aborts immediately: outputs drop to 0 in the same cycle.

## Test plan
- Reset, MEM_READY=1, OPCODE=000000 -> STATE sequence 0,1,6,7,0. ALU_OP=10 in EXECUTE. REG_WRITE=1 and REG_DST=1 only in ALUWB. INSTR_DONE pulses once.
- lw with MEM_READY=0 for 2 cycles in FETCH and 3 cycles in MEMRD -> 10 cycles total. IR_WRITE and PC_WRITE are high for exactly 1 cycle. MEM_TO_REG=1 only in MEMWB.
- beq with ZERO=1, then beq with ZERO=0 -> sequence 0,1,8 each time. ALU_OP=01 in BRANCH. PC_EN=1 in BRANCH only for the first instruction.
- sw with MEM_READY low for 4 cycles in MEMWR -> MEM_WRITE held for 5 cycles with I_OR_D=1. INSTR_DONE pulses on the ready cycle only.
- OPCODE=111111 -> ILLEGAL_OP=1 for 1 cycle in DECODE, then STATE=0. No REG_WRITE or MEM_WRITE asserted.
- RST pulsed in mid-cycle during MEMWR -> all outputs 0 immediately. STATE=0 after reset. The next instruction (j, 3 cycles, PC_SRC=10) executes normally.
